// File: rtl/fchk_pkg.sv
// Shared types and the acceptance rule for the fadd result checker.
// Defining FCHK_STRICT_EN removes the +/-1 ULP tolerance from fchk_pass.
package fchk_pkg;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;

  typedef struct packed {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] exp;
  } fchk_op_t;

  typedef struct packed {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic [31:0] exp;
  } fchk_entry_t;

  // Zero/denormal results on both sides compare equal regardless of mantissa.
  function automatic logic fchk_pass(input logic [31:0] y, input logic [31:0] exp);
    logic both_zero_exp;
    both_zero_exp = (exp[EXP_MSB:EXP_LSB] == '0) && (y[EXP_MSB:EXP_LSB] == '0);
`ifdef FCHK_STRICT_EN
    return both_zero_exp || (y == exp);
`else
    return both_zero_exp || (y == exp) || (y == exp + 32'd1) || (y == exp - 32'd1);
`endif
  endfunction

endpackage

// File: rtl/fadd_result_checker_if.sv
// Issue/result bus into the checker plus the mismatch drain port.
// master = environment (adder side and consumer), slave = checker.
interface fadd_result_checker_if;
  logic        issue_valid;
  logic [31:0] issue_x1;
  logic [31:0] issue_x2;
  logic [31:0] issue_exp;
  logic [31:0] y;
  logic        mm_valid;
  logic        mm_ready;
  logic [31:0] mm_x1;
  logic [31:0] mm_x2;
  logic [31:0] mm_y;
  logic [31:0] mm_exp;

  modport master (
    output issue_valid, issue_x1, issue_x2, issue_exp, y, mm_ready,
    input  mm_valid, mm_x1, mm_x2, mm_y, mm_exp
  );

  modport slave (
    input  issue_valid, issue_x1, issue_x2, issue_exp, y, mm_ready,
    output mm_valid, mm_x1, mm_x2, mm_y, mm_exp
  );
endinterface

// File: rtl/fchk_fifo.sv
// Mismatch queue: DEPTH entries, registered (no bypass), valid/ready pop, full flag.
// A push while full lands only if a pop happens in the same cycle; clear_i wins over both.
module fchk_fifo
  import fchk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear_i,
  input  logic        push_vld_i,
  input  fchk_entry_t push_dat_i,
  output logic        pop_vld_o,
  input  logic        pop_rdy_i,
  output fchk_entry_t pop_dat_o,
  output logic        full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  fchk_entry_t  mem_q [DEPTH];
  logic         empty, pop_fire, push_fire;

  // Extra pointer bit distinguishes full from empty.
  assign empty     = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_fire  = pop_rdy_i && !empty;
  assign push_fire = push_vld_i && (!full_o || pop_fire);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_fire) wr_d = wr_q + 1'b1;
      if (pop_fire)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire && !clear_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  assign pop_vld_o = !empty;
  assign pop_dat_o = empty ? '0 : mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/fadd_result_checker.sv
// Checks fadd results NSTAGE cycles after issue; counts checks/errors, queues mismatches.
// No stall: compares every cycle; drain is valid/ready. FCHK_STRICT_EN selects exact compare.
module fadd_result_checker
  import fchk_pkg::*;
#(
  parameter int NSTAGE     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 30
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  fadd_result_checker_if.slave  bus,
  output logic [CNT_W-1:0]      check_count,
  output logic [CNT_W-1:0]      err_count,
  output logic                  ovf
);
  logic [NSTAGE-1:0] vld_q;
  fchk_op_t          op_q [NSTAGE];
  fchk_op_t          tail_op;
  fchk_entry_t       push_dat, head_dat;
  logic              cmp_vld, cmp_pass, push_vld, fifo_full, pop_fire;
  logic [CNT_W-1:0]  check_q, check_d, err_q, err_d;
  logic              ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else if (clear) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= bus.issue_valid;
      for (int i = 1; i < NSTAGE; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Payload shifts freely; only the valids need reset/clear.
  always_ff @(posedge clk) begin
    op_q[0] <= '{x1: bus.issue_x1, x2: bus.issue_x2, exp: bus.issue_exp};
    for (int i = 1; i < NSTAGE; i++) op_q[i] <= op_q[i-1];
  end

  assign tail_op  = op_q[NSTAGE-1];
  assign cmp_vld  = vld_q[NSTAGE-1] && !clear;
  assign cmp_pass = fchk_pass(bus.y, tail_op.exp);
  assign push_vld = cmp_vld && !cmp_pass;
  assign push_dat = '{x1: tail_op.x1, x2: tail_op.x2, y: bus.y, exp: tail_op.exp};
  assign pop_fire = bus.mm_valid && bus.mm_ready;

  always_comb begin
    check_d = check_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (clear) begin
      check_d = '0;
      err_d   = '0;
      ovf_d   = 1'b0;
    end else if (cmp_vld) begin
      if (check_q != '1) check_d = check_q + CNT_W'(1);
      if (!cmp_pass) begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        if (fifo_full && !pop_fire) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      check_q <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      check_q <= check_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  fchk_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .clear_i    (clear),
    .push_vld_i (push_vld),
    .push_dat_i (push_dat),
    .pop_vld_o  (bus.mm_valid),
    .pop_rdy_i  (bus.mm_ready),
    .pop_dat_o  (head_dat),
    .full_o     (fifo_full)
  );

  assign bus.mm_x1  = head_dat.x1;
  assign bus.mm_x2  = head_dat.x2;
  assign bus.mm_y   = head_dat.y;
  assign bus.mm_exp = head_dat.exp;

  assign check_count = check_q;
  assign err_count   = err_q;
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_fadd_result_checker.sv
// Randomized and directed bench for fadd_result_checker against a queue-based reference model.
module tb_fadd_result_checker;
  localparam int NSTAGE = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W = 30;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  logic [CNT_W-1:0] check_count, err_count;
  logic ovf;

  fadd_result_checker_if bus();

  fadd_result_checker #(.NSTAGE(NSTAGE), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .bus(bus),
    .check_count(check_count), .err_count(err_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] x1, x2, exp; } pend_t;
  typedef struct { logic [31:0] x1, x2, y, exp; } mm_t;

  pend_t       m_pend[$];
  mm_t         m_q[$];
  longint      m_chk, m_err;
  bit          m_ovf;
  logic [31:0] y_sched [int];
  int          cyc;
  int          n_vec, n_err;

  // Acceptance rule from plain arithmetic: wrap difference and exponent fields.
  function automatic bit ref_pass(logic [31:0] y, logic [31:0] e);
    logic [31:0] d;
    d = y - e;
    if (((e >> 23) & 32'hFF) == 0 && ((y >> 23) & 32'hFF) == 0) return 1'b1;
`ifdef FCHK_STRICT_EN
    return d == 32'd0;
`else
    return d == 32'd0 || d == 32'd1 || d == 32'hFFFF_FFFF;
`endif
  endfunction

  function automatic void model_reset();
    m_pend.delete();
    m_q.delete();
    m_chk = 0;
    m_err = 0;
    m_ovf = 1'b0;
  endfunction

  // Effect of the coming clock edge, computed from the currently driven inputs.
  function automatic void model_edge();
    bit   pop, fail;
    mm_t  ent;
    pend_t op;
    if (clear) begin
      model_reset();
      return;
    end
    pop  = bus.mm_ready && m_q.size() > 0;
    fail = 1'b0;
    if (m_pend.size() > 0 && m_pend[0].due == cyc + 1) begin
      op = m_pend.pop_front();
      if (m_chk < CNT_MAX) m_chk++;
      if (!ref_pass(bus.y, op.exp)) begin
        fail = 1'b1;
        ent = '{x1: op.x1, x2: op.x2, y: bus.y, exp: op.exp};
      end
    end
    if (pop) void'(m_q.pop_front());
    if (fail) begin
      if (m_err < CNT_MAX) m_err++;
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(ent);
      else m_ovf = 1'b1;
    end
    if (bus.issue_valid) m_pend.push_back('{due: cyc + 1 + NSTAGE, x1: bus.issue_x1, x2: bus.issue_x2, exp: bus.issue_exp});
  endfunction

  task automatic step();
    int e;
    e = cyc + 1;
    if (y_sched.exists(e)) begin
      bus.y = y_sched[e];
      y_sched.delete(e);
    end else begin
      bus.y = $urandom;
    end
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle(input bit v, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [31:0] e, input logic [31:0] yv);
    bus.issue_valid = v;
    bus.issue_x1 = x1;
    bus.issue_x2 = x2;
    bus.issue_exp = e;
    if (v) y_sched[cyc + 1 + NSTAGE] = yv;
    step();
    bus.issue_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  function automatic logic [31:0] rand_normal();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'(8'h20 + $urandom_range(0, 8'h80));
    return v;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    bus.issue_valid = 1'b0;
    bus.mm_ready = 1'b0;
    bus.y = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (check_count !== '0) begin n_err++; $display("FAIL reset check_count got %0d want 0", check_count); end
    n_vec++; if (err_count !== '0) begin n_err++; $display("FAIL reset err_count got %0d want 0", err_count); end
    n_vec++; if (bus.mm_valid !== 1'b0) begin n_err++; $display("FAIL reset mm_valid got %b want 0", bus.mm_valid); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset ovf got %b want 0", ovf); end
    n_vec++; if ({bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp} !== 128'd0) begin n_err++; $display("FAIL reset mm_data got %h want 0", {bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp}); end
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_exact();
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000);
    idle(NSTAGE - 1);
    n_vec++; if (check_count !== '0) begin n_err++; $display("FAIL exact early_check got %0d want 0", check_count); end
    idle(1);
    n_vec++; if (check_count !== CNT_W'(1)) begin n_err++; $display("FAIL exact check_count got %0d want 1", check_count); end
    n_vec++; if (err_count !== m_err[CNT_W-1:0]) begin n_err++; $display("FAIL exact err_count got %0d want %0d", err_count, m_err); end
    n_vec++; if (bus.mm_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL exact mm_valid got %b want %b", bus.mm_valid, m_q.size() > 0); end
  endtask

  task automatic test_ulp();
    do_clear();
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0001);
    idle(NSTAGE);
    n_vec++; if (err_count !== m_err[CNT_W-1:0]) begin n_err++; $display("FAIL ulp err_count got %0d want %0d", err_count, m_err); end
    n_vec++; if (bus.mm_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL ulp mm_valid got %b want %b", bus.mm_valid, m_q.size() > 0); end
    if (m_q.size() > 0) begin
      n_vec++; if ({bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp} !== {m_q[0].x1, m_q[0].x2, m_q[0].y, m_q[0].exp}) begin n_err++; $display("FAIL ulp head got %h want %h", {bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp}, {m_q[0].x1, m_q[0].x2, m_q[0].y, m_q[0].exp}); end
    end
  endtask

  task automatic test_denorm();
    do_clear();
    cycle(1'b1, $urandom, $urandom, 32'h0000_0001, 32'h0040_0000);
    cycle(1'b1, $urandom, $urandom, 32'h0080_0000, 32'h0000_0000);
    idle(NSTAGE);
    n_vec++; if (check_count !== CNT_W'(2)) begin n_err++; $display("FAIL denorm check_count got %0d want 2", check_count); end
    n_vec++; if (err_count !== CNT_W'(1)) begin n_err++; $display("FAIL denorm err_count got %0d want 1", err_count); end
    n_vec++; if (bus.mm_exp !== 32'h0080_0000 || bus.mm_y !== 32'h0) begin n_err++; $display("FAIL denorm head got y=%h exp=%h want y=0 exp=00800000", bus.mm_y, bus.mm_exp); end
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    do_clear();
    bus.mm_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = rand_normal();
      cycle(1'b1, $urandom, $urandom, e, e + 32'd2 + 32'($urandom_range(0, 100)));
    end
    idle(NSTAGE);
    n_vec++; if (err_count !== CNT_W'(5)) begin n_err++; $display("FAIL ovf err_count got %0d want 5", err_count); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf flag got %b want 1", ovf); end
    bus.mm_ready = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      n_vec++; if (bus.mm_valid !== 1'b1 || m_q.size() == 0 || {bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp} !== {m_q[0].x1, m_q[0].x2, m_q[0].y, m_q[0].exp}) begin n_err++; $display("FAIL ovf drain%0d got v=%b %h want %h", i, bus.mm_valid, {bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp}, m_q.size() > 0 ? {m_q[0].x1, m_q[0].x2, m_q[0].y, m_q[0].exp} : 128'd0); end
      step();
    end
    bus.mm_ready = 1'b0;
    n_vec++; if (bus.mm_valid !== 1'b0) begin n_err++; $display("FAIL ovf drained mm_valid got %b want 0", bus.mm_valid); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf sticky got %b want 1", ovf); end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] e;
    int pops;
    do_clear();
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fullpp cleared_ovf got %b want 0", ovf); end
    bus.mm_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = rand_normal();
      cycle(1'b1, $urandom, $urandom, e, ~e);
      if (i == 3) idle(NSTAGE);
    end
    idle(NSTAGE - 1);
    bus.mm_ready = 1'b1;
    step();
    bus.mm_ready = 1'b0;
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fullpp ovf got %b want 0", ovf); end
    n_vec++; if (err_count !== CNT_W'(5)) begin n_err++; $display("FAIL fullpp err_count got %0d want 5", err_count); end
    pops = 0;
    bus.mm_ready = 1'b1;
    for (int i = 0; i < 10 && bus.mm_valid === 1'b1; i++) begin
      n_vec++; if (m_q.size() == 0 || {bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp} !== {m_q[0].x1, m_q[0].x2, m_q[0].y, m_q[0].exp}) begin n_err++; $display("FAIL fullpp head%0d got %h want %h", i, {bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp}, m_q.size() > 0 ? {m_q[0].x1, m_q[0].x2, m_q[0].y, m_q[0].exp} : 128'd0); end
      pops++;
      step();
    end
    bus.mm_ready = 1'b0;
    n_vec++; if (pops !== FIFO_DEPTH) begin n_err++; $display("FAIL fullpp occupancy got %0d want %0d", pops, FIFO_DEPTH); end
  endtask

  task automatic test_random();
    logic [31:0] e, yv;
    do_clear();
    for (int i = 0; i < 300; i++) begin
      bus.mm_ready = (i >= 100 && i < 140) ? 1'b0 : ($urandom_range(0, 3) != 0);
      e = $urandom;
      if ($urandom_range(0, 4) == 0) e[30:23] = 8'h00;
      case ($urandom_range(0, 6))
        0: yv = e;
        1: yv = e + 32'd1;
        2: yv = e - 32'd1;
        3: yv = e + 32'd2;
        4: yv = e - 32'd2;
        5: yv = {e[31], 8'h00, e[22:0] ^ 23'h1F};
        default: yv = $urandom;
      endcase
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, e, yv);
      n_vec++; if (check_count !== m_chk[CNT_W-1:0]) begin n_err++; $display("FAIL rand%0d check_count got %0d want %0d", i, check_count, m_chk); end
      n_vec++; if (err_count !== m_err[CNT_W-1:0]) begin n_err++; $display("FAIL rand%0d err_count got %0d want %0d", i, err_count, m_err); end
      n_vec++; if (ovf !== m_ovf) begin n_err++; $display("FAIL rand%0d ovf got %b want %b", i, ovf, m_ovf); end
      n_vec++; if (bus.mm_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL rand%0d mm_valid got %b want %b", i, bus.mm_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        n_vec++; if ({bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp} !== {m_q[0].x1, m_q[0].x2, m_q[0].y, m_q[0].exp}) begin n_err++; $display("FAIL rand%0d head got %h want %h", i, {bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp}, {m_q[0].x1, m_q[0].x2, m_q[0].y, m_q[0].exp}); end
      end
    end
    bus.mm_ready = 1'b0;
  endtask

  task automatic test_clear_midflight();
    logic [31:0] e;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      e = rand_normal();
      cycle(1'b1, $urandom, $urandom, e, ~e);
    end
    do_clear();
    idle(NSTAGE + 2);
    n_vec++; if (check_count !== '0) begin n_err++; $display("FAIL midclear check_count got %0d want 0", check_count); end
    n_vec++; if (err_count !== '0) begin n_err++; $display("FAIL midclear err_count got %0d want 0", err_count); end
    n_vec++; if (bus.mm_valid !== 1'b0) begin n_err++; $display("FAIL midclear mm_valid got %b want 0", bus.mm_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] e;
    bus.mm_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      e = rand_normal();
      cycle(1'b1, $urandom, $urandom, e, ~e);
    end
    idle(1);
    for (int i = 0; i < 3; i++) begin
      e = rand_normal();
      cycle(1'b1, $urandom, $urandom, e, ~e);
    end
    rstn = 1'b0;
    #1;
    n_vec++; if (check_count !== '0) begin n_err++; $display("FAIL midreset check_count got %0d want 0", check_count); end
    n_vec++; if (err_count !== '0) begin n_err++; $display("FAIL midreset err_count got %0d want 0", err_count); end
    n_vec++; if (bus.mm_valid !== 1'b0) begin n_err++; $display("FAIL midreset mm_valid got %b want 0", bus.mm_valid); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL midreset ovf got %b want 0", ovf); end
    n_vec++; if ({bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp} !== 128'd0) begin n_err++; $display("FAIL midreset mm_data got %h want 0", {bus.mm_x1, bus.mm_x2, bus.mm_y, bus.mm_exp}); end
    model_reset();
    #2;
    rstn = 1'b1;
    idle(NSTAGE + 2);
    n_vec++; if (check_count !== '0) begin n_err++; $display("FAIL midreset post check_count got %0d want 0", check_count); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    bus.issue_x1 = '0;
    bus.issue_x2 = '0;
    bus.issue_exp = '0;
    model_reset();
    test_reset();
    test_exact();
    test_ulp();
    test_denorm();
    test_overflow();
    test_full_pushpop();
    test_random();
    test_clear_midflight();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fadd_result_checker.md
# fadd_result_checker

Synthesizable result-side monitor for the pipelined `fadd` unit. It sits on the output end of the adder. For every issued operation it carries the operands and an externally supplied expected sum through a delay line matched to the adder latency. It compares the adder's `y` against the expected value under the team's ±1 ULP / zero-exponent acceptance rule, keeps pass/fail statistics, and queues mismatches for readout through a valid/ready drain port.

## Interface
- `NSTAGE`, 3, adder latency in cycles; legal range 1..8.
- `FIFO_DEPTH`, 4, mismatch queue entries; power of two, at least 2.
- `CNT_W`, 30, width of the statistics counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset; asynchronous assert, active-low.
- `clear`  in  1  synchronous clear of counters, queue, delay line and `ovf`.
- `issue_valid`  in  1  an operation is presented to `fadd` this cycle.
- `issue_x1`, `issue_x2`  in  32  operands, the same values driven to `fadd` this cycle.
- `issue_exp`  in  32  expected IEEE-754 single-precision sum.
- `y`  in  32  `fadd` result.
- `check_count`  out  CNT_W  number of comparisons performed.
- `err_count`  out  CNT_W  number of comparisons that failed.
- `mm_valid`  out  1  mismatch queue is non-empty.
- `mm_ready`  in  1  consumer accepts the head entry.
- `mm_x1`, `mm_x2`, `mm_y`, `mm_exp`  out  32 each  fields of the head entry.
- `ovf`  out  1  sticky; a mismatch was dropped because the queue was full.

## Operation
- **Delay line.**
  - NSTAGE-deep shift register of {valid, x1, x2, exp}.
  - Advances every cycle unconditionally; no stall input.
- **Compare.** Occurs when the tail entry is valid. `check_count` increments.
- **Pass condition.** Any one of:
  - `exp[30:23]==0` and `y[30:23]==0` (both zero or denormal, treated as equal);
  - `y==exp`, `y==exp+1` or `y==exp-1`, using 32-bit unsigned wrap arithmetic.
- **Fail.**
  - `err_count` increments.
  - {x1, x2, y, exp} is pushed to the queue.
  - If the queue is full and not popping in the same cycle, the entry is dropped and `ovf` sets.
- **Saturation.** Both counters saturate at all-ones; no wrap.
- **Drain.** A pop occurs when `mm_valid && mm_ready`. Head outputs are held stable while `mm_valid` is high and `mm_ready` is low.
- **Simultaneous push and pop.**
  - Queue full: both occur and the push is not dropped.
  - Queue empty: the pop is ignored and the push lands.
- **`clear`.**
  - Zeroes the counters, queue pointers, delay-line valids and `ovf`.
  - Has priority over a same-cycle compare, push or pop.
  - In-flight operations are discarded and never checked.
- **Reset values.**
  - `check_count`=0, `err_count`=0, `mm_valid`=0, `ovf`=0.
  - `mm_*` data outputs = 0.
  - All delay-line valids = 0.
- **Reset mid-operation.** Same effect as `clear`; takes effect asynchronously.

## Timing
- **Alignment.** An issue sampled at edge t is compared against `y` sampled at edge t+NSTAGE.
- **Compare visibility.** Counter updates and the push are visible after edge t+NSTAGE.
- **Queue flow-through.** `mm_valid` rises one cycle after the push edge; there is no same-cycle bypass.
- **Throughput.** One issue per cycle, back-to-back; one compare per cycle.
- **Pop.** The head advances on the pop edge. The next entry, if any, is on `mm_*` in the following cycle.

## Configuration
- `FCHK_STRICT_EN`
  - **Defined:** the ±1 ULP tolerance is removed. Pass requires `y==exp`, or both exponent fields zero.
  - **Undefined (default):** the tolerant rule above applies.

## Structure
- **Package `fchk_pkg`:**
  - `fchk_entry_t` packed struct {x1, x2, y, exp};
  - `fchk_pass` function implementing the pass condition, including the macro switch;
  - `EXP_MSB`/`EXP_LSB` constants (30/23).
- **Sub-module `fchk_fifo`:**
  - Parameterized FIFO of `fchk_entry_t` with valid/ready pop and a full flag.
  - Same clock and reset as the parent.

## Test plan
- **Exact match.** Issue x1=0x3F800000, x2=0x40000000, exp=0x40400000; `y`=0x40400000 at t+3 -> `check_count`=1, `err_count`=0, `mm_valid`=0.
- **ULP tolerance.** Same issue with `y`=0x40400001 -> pass by default. With `FCHK_STRICT_EN` -> `err_count`=1, queue head {0x3F800000, 0x40000000, 0x40400001, 0x40400000}.
- **Denormal exemption.** exp=0x00000001, `y`=0x00400000 -> pass in both configurations. exp=0x00800000, `y`=0x00000000 -> fail.
- **Queue overflow.** Five consecutive failures with `mm_ready`=0 and `FIFO_DEPTH`=4 -> 4 entries queued, `ovf`=1, `err_count`=5. Drain with `mm_ready`=1 -> entries appear in issue order, then `mm_valid`=0.
- **Full queue, push and pop together.** Fill 4 entries; hold `mm_ready`=1 while a new failure compares -> `ovf` stays 0 and the occupancy stays 4.
- **Mid-flight clear and reset.** Issue 3 operations, assert `clear` at t+1 -> no compares occur and `check_count`=0. Repeat with `rstn` pulsed low between edges -> all outputs 0 immediately.
